vram_arbiter: RTL
=================

# vram_arbiter

Single-port video RAM arbiter between the MC6847-style display fetch engine and the Z80 CPU bus. The display side has priority on every pixel-clock cycle in which it requests a byte. CPU accesses are latched, held pending and issued in the first free RAM cycle, with Z80 WAIT_N stretching the bus cycle meanwhile. Optionally, a starved CPU steals a slot and the display receives the CPU's byte, reproducing the VZ200 "snow" artefact.

## Interface
- AW, 15, RAM address width (32KB span; covers 24KB SSHRG mode)
- STARVE_LIMIT, 64, pending-cycle count after which a CPU access may steal a display slot (only with steal feature; 1..255)

- PIX_CLK  in  1  sole clock; all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- DISP_RD  in  1  display read request, one byte per asserted cycle
- DISP_DA  in  AW  display read address, valid with DISP_RD
- DISP_DD  out  8  display read data, registered
- CPU_REQ  in  1  CPU access request, level; address/data/CPU_WR stable while high
- CPU_WR  in  1  1 = write, 0 = read
- CPU_A  in  AW  CPU address
- CPU_DO  in  8  CPU write data
- CPU_DI  out  8  CPU read data, valid while CPU_ACK high and held afterwards
- CPU_ACK  out  1  one-cycle completion pulse
- CPU_WAIT_N  out  1  active-low wait to Z80
- RAM_A  out  AW  RAM address (combinational from grant)
- RAM_WE  out  1  RAM write enable
- RAM_DI  out  8  RAM write data
- RAM_DO  in  8  synchronous RAM read data, one cycle after RAM_A
- STEAL  out  1  one-cycle pulse when a display slot was stolen (0 without steal feature)

## Operation
- FSM states: IDLE, PEND, XFER, DONE.
- IDLE: when CPU_REQ=1, latch CPU_A/CPU_DO/CPU_WR into request registers; go to PEND; drive CPU_WAIT_N=0 from the next cycle.
- PEND: grant goes to CPU when DISP_RD=0 (or on steal). RAM_A is the latched address, RAM_WE is the latched write, and RAM_DI is the latched data. Next state is XFER. Otherwise the display keeps the grant and the 8-bit saturating wait counter increments.
- XFER: for a read, CPU_DI <= RAM_DO. Assert CPU_ACK=1 and CPU_WAIT_N=1, then go to DONE. Writes also pass through XFER (ACK one cycle after the write).
- DONE: stay until CPU_REQ=0, then go to IDLE. A new request requires at least one cycle of CPU_REQ low.
- Display grant: RAM_A=DISP_DA, RAM_WE=0. Capture flag d1 <= display-owned. When d1 is set, DISP_DD <= RAM_DO; otherwise DISP_DD holds.
- Idle RAM: RAM_A=0, RAM_WE=0.
- Wait counter clears on entry to PEND.
- CPU_REQ dropped while in PEND is ignored; the latched access still completes.

## Timing
- Reset values: DISP_DD=0, CPU_DI=0, CPU_ACK=0, CPU_WAIT_N=1, RAM_WE=0, RAM_A=0, RAM_DI=0, STEAL=0, state IDLE, counter 0.
- Display latency: DISP_RD at cycle n gives DISP_DD valid from cycle n+2. The display is never delayed except by a steal.
- CPU best case: REQ seen in cycle n (IDLE), RAM issue in n+1, ACK in n+2.
- CPU_WAIT_N is low from n+1 through the cycle before ACK.
- Simultaneous DISP_RD and CPU issue in PEND: display wins (no steal).
- Reset mid-access: everything returns to reset values immediately. A write in flight is aborted if RAM_WE has not been sampled.

## Configuration
- VRAM_STEAL_EN defined:
  - In PEND, when the counter is ≥ STARVE_LIMIT and DISP_RD=1, the CPU takes the slot and STEAL pulses.
  - The display capture for that slot loads the CPU byte: CPU_DO for a write, RAM_DO for a read. This produces snow.
- VRAM_STEAL_EN undefined: strict display priority, unbounded CPU wait, STEAL tied 0, counter logic removed.

## Test plan
- Reset: hold RESET_N low with random inputs -> all outputs at reset values and CPU_WAIT_N=1.
- CPU write with DISP_RD=0: A=0x1234, DO=0x5A -> RAM_WE=1 with RAM_A=0x1234 one cycle after REQ; ACK two cycles after REQ; a later read returns CPU_DI=0x5A.
- Display stream: DISP_RD=1 with DA=0x0000..0x001F, RAM preloaded with addr[7:0] -> DISP_DD sequence 0x00..0x1F, each value two cycles after its request.
- Contention without steal: CPU read while DISP_RD=1 for 100 cycles, then 0 -> CPU_WAIT_N low throughout; RAM issue in the first DISP_RD=0 cycle; display data uncorrupted.
- VRAM_STEAL_EN with STARVE_LIMIT=4: CPU write 0xAA during continuous DISP_RD -> STEAL after 4 pending cycles; DISP_DD=0xAA for that slot; ACK the following cycle.
- Reset asserted in PEND -> IDLE immediately, no RAM_WE and no ACK after release.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has priority, CPU accesses wait via CPU_WAIT_N.
// Define VRAM_STEAL_EN to let a starved CPU steal a display slot (VZ200-style snow).
module vram_arbiter #(
  parameter int AW           = 15,
  parameter int STARVE_LIMIT = 64
) (
  input  logic          PIX_CLK,
  input  logic          RESET_N,
  input  logic          DISP_RD,
  input  logic [AW-1:0] DISP_DA,
  output logic [7:0]    DISP_DD,
  input  logic          CPU_REQ,
  input  logic          CPU_WR,
  input  logic [AW-1:0] CPU_A,
  input  logic [7:0]    CPU_DO,
  output logic [7:0]    CPU_DI,
  output logic          CPU_ACK,
  output logic          CPU_WAIT_N,
  output logic [AW-1:0] RAM_A,
  output logic          RAM_WE,
  output logic [7:0]    RAM_DI,
  input  logic [7:0]    RAM_DO,
  output logic          STEAL
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("vram_arbiter: STARVE_LIMIT must be within 1..255");
  end

  typedef enum logic [1:0] {IDLE, PEND, XFER, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] req_a;
  logic [7:0]    req_do;
  logic          req_wr;
  logic          cpu_grant;
  logic          disp_grant;
  logic          steal;
  logic          d1;
  logic [7:0]    disp_dd_q;
  logic [7:0]    cpu_di_q;

`ifdef VRAM_STEAL_EN
  logic [7:0] wait_cnt;
  logic       snow_wr;
  logic [7:0] snow_data;

  assign steal = (state == PEND) && DISP_RD && (wait_cnt >= 8'(STARVE_LIMIT));

  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wait_cnt <= 8'd0;
    end else if (state == IDLE && CPU_REQ) begin
      wait_cnt <= 8'd0;
    end else if (state == PEND && !cpu_grant && wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // A stolen write slot shows the CPU's byte on the display, not stale RAM output.
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      snow_wr   <= 1'b0;
      snow_data <= 8'd0;
    end else begin
      snow_wr   <= steal && req_wr;
      snow_data <= req_do;
    end
  end
`else
  assign steal = 1'b0;
`endif

  assign cpu_grant  = (state == PEND) && (!DISP_RD || steal);
  assign disp_grant = RESET_N && DISP_RD && !cpu_grant;

  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      req_a  <= '0;
      req_do <= 8'd0;
      req_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && CPU_REQ) begin
        req_a  <= CPU_A;
        req_do <= CPU_DO;
        req_wr <= CPU_WR;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    CPU_ACK    = 1'b0;
    CPU_WAIT_N = 1'b1;
    case (state)
      IDLE: if (CPU_REQ) state_nxt = PEND;
      PEND: begin
        CPU_WAIT_N = 1'b0;
        if (cpu_grant) state_nxt = XFER;
      end
      XFER: begin
        CPU_ACK   = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (!CPU_REQ) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    RAM_A  = '0;
    RAM_WE = 1'b0;
    RAM_DI = 8'd0;
    if (cpu_grant) begin
      RAM_A  = req_a;
      RAM_WE = req_wr;
      RAM_DI = req_do;
    end else if (disp_grant) begin
      RAM_A = DISP_DA;
    end
  end

  // d1 marks that the RAM output in this cycle belongs to a display slot.
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      d1        <= 1'b0;
      disp_dd_q <= 8'd0;
      cpu_di_q  <= 8'd0;
    end else begin
      d1 <= disp_grant || steal;
      if (d1) begin
`ifdef VRAM_STEAL_EN
        disp_dd_q <= snow_wr ? snow_data : RAM_DO;
`else
        disp_dd_q <= RAM_DO;
`endif
      end
      if (state == XFER && !req_wr) cpu_di_q <= RAM_DO;
    end
  end

  // Read data bypasses the register during the ACK cycle so it is valid alongside ACK.
  assign CPU_DI  = (state == XFER && !req_wr) ? RAM_DO : cpu_di_q;
  assign DISP_DD = disp_dd_q;
  assign STEAL   = steal;

endmodule
